ps2_letter_decoder: RTL and testbench

//  Converts the byte stream from the PS/2 keyboard controller into clean one-hot letter strobes
//  for the rotor/reflector stage (rero). Sits directly upstream of rero.

---
 rtl/ps2_letter_decoder.sv | 179 +++++++++++++++++
 tb/tb_ps2_letter_decoder.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/ps2_letter_decoder.sv
// PS/2 set-2 byte stream to one-hot letter strobes, with break/extended prefix handling
// and typematic repeat suppression. Optional 7-seg display of the last raw byte: DECODER_HEX_EN.
module ps2_letter_decoder #(
  parameter int PREFIX_TIMEOUT = 1_000_000,
  parameter bit REPEAT_FILTER  = 1'b1
) (
  input  logic        CLOCK_50,
  input  logic        reset,
  input  logic [7:0]  scan_code,
  input  logic        scan_ready,
  output logic        read,
  output logic [25:0] letter_onehot,
  output logic [4:0]  letter_index,
  output logic        letter_valid,
  output logic        key_held
`ifdef DECODER_HEX_EN
  ,
  output logic [6:0]  HEX0,
  output logic [6:0]  HEX1
`endif
);

  localparam int TW = $clog2(PREFIX_TIMEOUT + 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(PREFIX_TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BRK     = 2'd1,
    EXT     = 2'd2,
    EXT_BRK = 2'd3
  } state_t;

  state_t        state;
  logic [TW-1:0] timer;
  logic          sr_q;
  logic          accept;
  logic          hit;
  logic [4:0]    code_idx;
  logic          is_repeat;
  logic          timed_out;

  // Set-2 make code to letter position; msb flags a letter.
  function automatic logic [5:0] letter_lookup(input logic [7:0] code);
    case (code)
      8'h1C: letter_lookup = {1'b1, 5'd0};
      8'h32: letter_lookup = {1'b1, 5'd1};
      8'h21: letter_lookup = {1'b1, 5'd2};
      8'h23: letter_lookup = {1'b1, 5'd3};
      8'h24: letter_lookup = {1'b1, 5'd4};
      8'h2B: letter_lookup = {1'b1, 5'd5};
      8'h34: letter_lookup = {1'b1, 5'd6};
      8'h33: letter_lookup = {1'b1, 5'd7};
      8'h43: letter_lookup = {1'b1, 5'd8};
      8'h3B: letter_lookup = {1'b1, 5'd9};
      8'h42: letter_lookup = {1'b1, 5'd10};
      8'h4B: letter_lookup = {1'b1, 5'd11};
      8'h3A: letter_lookup = {1'b1, 5'd12};
      8'h31: letter_lookup = {1'b1, 5'd13};
      8'h44: letter_lookup = {1'b1, 5'd14};
      8'h4D: letter_lookup = {1'b1, 5'd15};
      8'h15: letter_lookup = {1'b1, 5'd16};
      8'h2D: letter_lookup = {1'b1, 5'd17};
      8'h1B: letter_lookup = {1'b1, 5'd18};
      8'h2C: letter_lookup = {1'b1, 5'd19};
      8'h3C: letter_lookup = {1'b1, 5'd20};
      8'h2A: letter_lookup = {1'b1, 5'd21};
      8'h1D: letter_lookup = {1'b1, 5'd22};
      8'h22: letter_lookup = {1'b1, 5'd23};
      8'h35: letter_lookup = {1'b1, 5'd24};
      8'h1A: letter_lookup = {1'b1, 5'd25};
      default: letter_lookup = {1'b0, 5'd0};
    endcase
  endfunction

`ifdef DECODER_HEX_EN
  // Active-low segment pattern {g,f,e,d,c,b,a} for one hex digit.
  function automatic logic [6:0] seg7(input logic [3:0] n);
    case (n)
      4'h0: seg7 = 7'b1000000;
      4'h1: seg7 = 7'b1111001;
      4'h2: seg7 = 7'b0100100;
      4'h3: seg7 = 7'b0110000;
      4'h4: seg7 = 7'b0011001;
      4'h5: seg7 = 7'b0010010;
      4'h6: seg7 = 7'b0000010;
      4'h7: seg7 = 7'b1111000;
      4'h8: seg7 = 7'b0000000;
      4'h9: seg7 = 7'b0010000;
      4'hA: seg7 = 7'b0001000;
      4'hB: seg7 = 7'b0000011;
      4'hC: seg7 = 7'b1000110;
      4'hD: seg7 = 7'b0100001;
      4'hE: seg7 = 7'b0000110;
      4'hF: seg7 = 7'b0001110;
      default: seg7 = 7'b1111111;
    endcase
  endfunction
`endif

  // Rising edge of scan_ready accepts a byte; decode flags for the current byte.
  always_comb begin
    accept                = scan_ready & ~sr_q;
    {hit, code_idx}       = letter_lookup(scan_code);
    is_repeat             = (REPEAT_FILTER == 1'b1) && key_held && (code_idx == letter_index);
    timed_out             = (state != IDLE) && (timer == TIMER_LAST);
  end

  // Prefix FSM, prefix timer and all registered outputs.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      timer         <= '0;
      sr_q          <= 1'b0;
      read          <= 1'b0;
      letter_onehot <= 26'd0;
      letter_index  <= 5'd0;
      letter_valid  <= 1'b0;
      key_held      <= 1'b0;
`ifdef DECODER_HEX_EN
      HEX0          <= 7'b1000000;
      HEX1          <= 7'b1000000;
`endif
    end else begin
      sr_q         <= scan_ready;
      read         <= accept;
      letter_valid <= 1'b0;
      if (accept) begin
        // A byte always restarts the timer; only prefix states look at it.
        timer <= '0;
`ifdef DECODER_HEX_EN
        HEX0  <= seg7(scan_code[3:0]);
        HEX1  <= seg7(scan_code[7:4]);
`endif
        case (state)
          IDLE: begin
            if (scan_code == 8'hF0) begin
              state <= BRK;
            end else if (scan_code == 8'hE0) begin
              state <= EXT;
            end else if (hit && !is_repeat) begin
              letter_onehot <= 26'd1 << code_idx;
              letter_index  <= code_idx;
              letter_valid  <= 1'b1;
              key_held      <= 1'b1;
            end else begin
              state <= IDLE;
            end
          end
          BRK: begin
            if (scan_code == 8'hF0) begin
              state <= BRK;
            end else begin
              if (hit && key_held && (code_idx == letter_index)) begin
                key_held <= 1'b0;
              end
              state <= IDLE;
            end
          end
          EXT: begin
            if (scan_code == 8'hF0) begin
              state <= EXT_BRK;
            end else begin
              state <= IDLE;
            end
          end
          EXT_BRK: state <= IDLE;
          default: state <= IDLE;
        endcase
      end else if (timed_out) begin
        state <= IDLE;
      end else if ((state != IDLE) && (timer != TIMER_LAST)) begin
        timer <= timer + TW'(1);
      end else begin
        timer <= timer;
      end
    end
  end

endmodule

// File: tb/tb_ps2_letter_decoder.sv
// Scoreboard bench for ps2_letter_decoder: stimulus pushes expected letter events,
// a negedge monitor pops and compares on every letter_valid pulse.
module tb_ps2_letter_decoder;

  localparam int TO = 64;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  scan_code;
  logic        scan_ready;
  logic        read;
  logic [25:0] letter_onehot;
  logic [4:0]  letter_index;
  logic        letter_valid;
  logic        key_held;
`ifdef DECODER_HEX_EN
  logic [6:0]  HEX0;
  logic [6:0]  HEX1;
`endif

  int tests = 0;
  int fails = 0;
  int read_cnt = 0;
  logic [30:0] exp_q[$];

  ps2_letter_decoder #(.PREFIX_TIMEOUT(TO), .REPEAT_FILTER(1'b1)) dut (
    .CLOCK_50      (clk),
    .reset         (reset),
    .scan_code     (scan_code),
    .scan_ready    (scan_ready),
    .read          (read),
    .letter_onehot (letter_onehot),
    .letter_index  (letter_index),
    .letter_valid  (letter_valid),
    .key_held      (key_held)
`ifdef DECODER_HEX_EN
    ,
    .HEX0          (HEX0),
    .HEX1          (HEX1)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [25:0] oh, input logic [4:0] idx);
    exp_q.push_back({idx, oh});
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    scan_code  = b;
    scan_ready = 1'b1;
    repeat (2) @(negedge clk);
    scan_ready = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  // Read pulse counter and letter event monitor.
  always @(negedge clk) begin
    if (read) read_cnt++;
    if (!reset && letter_valid) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_letter: got index %0d, expected no event", letter_index);
      end else begin
        logic [30:0] e;
        e = exp_q.pop_front();
        check("letter_onehot", {6'd0, letter_onehot}, {6'd0, e[25:0]});
        check("letter_index", {27'd0, letter_index}, {27'd0, e[30:26]});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int rc;
    reset      = 1'b1;
    scan_code  = 8'h00;
    scan_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs", {read, letter_valid, key_held, letter_index, letter_onehot},
          {1'b0, 1'b0, 1'b0, 5'd0, 26'd0});
`ifdef DECODER_HEX_EN
    check("reset_hex", {18'd0, HEX1, HEX0}, {18'd0, 7'b1000000, 7'b1000000});
`endif
    reset = 1'b0;
    @(negedge clk);

    // 1: A with latency check
    push_exp(26'h1, 5'd0);
    @(negedge clk);
    scan_code  = 8'h1C;
    scan_ready = 1'b1;
    @(negedge clk);
    check("latency_read_valid", {30'd0, read, letter_valid}, {30'd0, 2'b11});
    @(negedge clk);
    check("read_one_cycle", {31'd0, read}, 32'd0);
    scan_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("held_after_A", {31'd0, key_held}, 32'd1);

    // 2: typematic repeats suppressed, break, fresh press
    send_byte(8'h1C);
    send_byte(8'h1C);
    send_byte(8'hF0);
    send_byte(8'h1C);
    check("held_after_break_A", {31'd0, key_held}, 32'd0);
    push_exp(26'h1, 5'd0);
    send_byte(8'h1C);
    check("held_after_repress", {31'd0, key_held}, 32'd1);

    // 3: Z then Y replaces; break of Z keeps hold
    push_exp(26'h2000000, 5'd25);
    send_byte(8'h1A);
    push_exp(26'h1000000, 5'd24);
    send_byte(8'h35);
    check("held_after_Y", {31'd0, key_held}, 32'd1);
    send_byte(8'hF0);
    send_byte(8'h1A);
    check("held_after_break_Z", {31'd0, key_held}, 32'd1);
    send_byte(8'hF0);
    send_byte(8'h35);
    check("held_after_break_Y", {31'd0, key_held}, 32'd0);

    // 4: extended break is discarded
    rc = read_cnt;
    send_byte(8'hE0);
    send_byte(8'hF0);
    send_byte(8'h1C);
    check("ext_read_pulses", read_cnt - rc, 32'd3);
    check("ext_onehot_kept", {6'd0, letter_onehot}, {6'd0, 26'h1000000});
    push_exp(26'h20000, 5'd17);
    send_byte(8'h2D);

    // 5: prefix timeout then C decodes as make
    send_byte(8'hF0);
    repeat (TO + 5) @(negedge clk);
    push_exp(26'h4, 5'd2);
    send_byte(8'h21);
    check("held_after_C", {31'd0, key_held}, 32'd1);

    // reset while in BRK with a byte pending
    send_byte(8'hF0);
    scan_code  = 8'h21;
    scan_ready = 1'b1;
    reset      = 1'b1;
    @(negedge clk);
    check("reset_in_brk", {read, letter_valid, key_held, letter_index, letter_onehot},
          {1'b0, 1'b0, 1'b0, 5'd0, 26'd0});
    scan_ready = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    push_exp(26'h1, 5'd0);
    send_byte(8'h1C);

    // 6: level held high gives one accept; M also exercises the display
    rc = read_cnt;
    push_exp(26'h1000, 5'd12);
    @(negedge clk);
    scan_code  = 8'h3A;
    scan_ready = 1'b1;
    repeat (100) @(negedge clk);
    scan_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("level_one_read", read_cnt - rc, 32'd1);
`ifdef DECODER_HEX_EN
    check("hex_3A", {18'd0, HEX1, HEX0}, {18'd0, 7'b0110000, 7'b0001000});
`endif

    repeat (4) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
